// File: rtl/clock_button_ctrl.sv
// Single-button UI controller for the digital clock.
// The raw button is synchronized and debounced, each press is classified as
// short or long, and the press events drive mode/select/increment/clear.
module clock_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int TIMEOUT_CYCLES  = 1_000_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic [1:0] mode,
    output logic [1:0] select,
    output logic       editing,
    output logic       increment,
    output logic       clear,
    output logic       btn_db
);

    // state | meaning
    // RUN   | clock running; short press cycles mode, long press edits or clears
    // EDIT  | field edit; short press increments, long press advances select
    typedef enum logic {
        S_RUN  = 1'b0,
        S_EDIT = 1'b1
    } state_t;

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    // The level flips on the edge where the count of mismatching cycles
    // reaches DEBOUNCE_CYCLES, so compare against one less than that.
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    state_t            state;
    logic              btn_meta;
    logic              btn_sync;
    logic [DB_W-1:0]   db_cnt;
    logic              db_toggle;
    logic              btn_db_next;
    logic              btn_db_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_fired;
    logic              long_ev;
    logic              short_ev;
    logic [TO_W-1:0]   to_cnt;
    logic              timeout_ev;

    assign db_toggle   = (btn_sync != btn_db) && (db_cnt == DB_LAST);
    assign btn_db_next = btn_db ^ db_toggle;

    // Long fires once per press; short only on release of a press that never went long.
    assign long_ev    = (hold_cnt == HOLD_MAX) && !long_fired;
    assign short_ev   = btn_db_q && !btn_db && !long_fired;
    assign timeout_ev = (state == S_EDIT) && (to_cnt == TO_MAX);

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    // Debounce: count consecutive cycles the synchronized input disagrees with btn_db.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            if ((btn_sync == btn_db) || db_toggle)
                db_cnt <= '0;
            else
                db_cnt <= db_cnt + 1'b1;
            btn_db   <= btn_db_next;
            btn_db_q <= btn_db;
        end
    end

    // Hold length of the current press; loads 1 together with the rising btn_db.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt   <= '0;
            long_fired <= 1'b0;
        end else begin
            if (!btn_db_next)
                hold_cnt <= '0;
            else if (hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + 1'b1;

            // Kept through the release cycle so the short event can be suppressed.
            if (long_ev)
                long_fired <= 1'b1;
            else if (!btn_db)
                long_fired <= 1'b0;
        end
    end

    // Edit inactivity timer: runs only while released in EDIT, restarts on every btn_db edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if ((state != S_EDIT) || db_toggle || long_ev) begin
            to_cnt <= '0;
        end else if (!btn_db && (to_cnt != TO_MAX)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Control FSM with registered outputs; press events take priority over timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RUN;
            mode      <= 2'd0;
            select    <= 2'd0;
            editing   <= 1'b0;
            increment <= 1'b0;
            clear     <= 1'b0;
        end else begin
            increment <= 1'b0;
            clear     <= 1'b0;
            case (state)
                S_RUN: begin
                    if (short_ev) begin
                        mode <= (mode == 2'd2) ? 2'd0 : mode + 2'd1;
                    end else if (long_ev) begin
                        if (mode == 2'd2) begin
                            clear <= 1'b1;
                        end else begin
                            state   <= S_EDIT;
                            editing <= 1'b1;
                            select  <= 2'd0;
                        end
                    end
                end
                S_EDIT: begin
                    if (short_ev) begin
                        increment <= 1'b1;
                    end else if (long_ev) begin
                        if (select == 2'd2) begin
                            state   <= S_RUN;
                            editing <= 1'b0;
                            select  <= 2'd0;
                        end else begin
                            select <= select + 2'd1;
                        end
                    end else if (timeout_ev) begin
                        state   <= S_RUN;
                        editing <= 1'b0;
                        select  <= 2'd0;
                    end
                end
                default: begin
                    state   <= S_RUN;
                    editing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_button_ctrl.sv
// Directed bench for clock_button_ctrl with small debounce/long/timeout values.
module tb_clock_button_ctrl;

    localparam int DB = 4;
    localparam int LG = 20;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn;
    logic [1:0] mode;
    logic [1:0] select;
    logic       editing;
    logic       increment;
    logic       clear;
    logic       btn_db;

    int vectors     = 0;
    int miscompares = 0;
    int inc_seen    = 0;
    int clr_seen    = 0;
    logic inc_prev  = 1'b0;
    logic clr_prev  = 1'b0;

    typedef struct {
        logic b;
        int   n;
        int   m;
        int   s;
        int   ed;
        int   db;
        int   inc;
        int   clr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    clock_button_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .mode     (mode),
        .select   (select),
        .editing  (editing),
        .increment(increment),
        .clear    (clear),
        .btn_db   (btn_db)
    );

    function automatic void add(logic b, int n, int m, int s, int ed, int db, int inc, int clr);
        vec_t v;
        v.b = b; v.n = n; v.m = m; v.s = s; v.ed = ed; v.db = db; v.inc = inc; v.clr = clr;
        vecs.push_back(v);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int m, input int s, input int ed,
                           input int db, input int inc, input int clr);
        chk({tag, " mode"},    int'(mode),    m);
        chk({tag, " select"},  int'(select),  s);
        chk({tag, " editing"}, int'(editing), ed);
        chk({tag, " btn_db"},  int'(btn_db),  db);
        chk({tag, " inc_cnt"}, inc_seen,      inc);
        chk({tag, " clr_cnt"}, clr_seen,      clr);
    endtask

    // Pulse counting and one-cycle width check, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (increment) begin
                inc_seen++;
                vectors++;
                if (inc_prev) begin
                    miscompares++;
                    $display("FAIL increment width: got high 2 cycles, expected 1");
                end
            end
            if (clear) begin
                clr_seen++;
                vectors++;
                if (clr_prev) begin
                    miscompares++;
                    $display("FAIL clear width: got high 2 cycles, expected 1");
                end
            end
            if (mode == 2'd3 || select == 2'd3) begin
                miscompares++;
                $display("FAIL illegal code: mode %0d select %0d, expected neither 3", mode, select);
            end
        end
        inc_prev = increment;
        clr_prev = clear;
    end

    initial begin
        // Short presses: btn_db rises 6 edges after press, mode moves 1 edge after release edge.
        add(1, 5, 0,0,0,0, 0,0);
        add(1, 1, 0,0,0,1, 0,0);
        add(1, 4, 0,0,0,1, 0,0);
        add(0, 6, 0,0,0,0, 0,0);
        add(0, 1, 1,0,0,0, 0,0);
        add(1,10, 1,0,0,1, 0,0);
        add(0, 7, 2,0,0,0, 0,0);
        add(1,10, 2,0,0,1, 0,0);
        add(0, 7, 0,0,0,0, 0,0);
        // 3-cycle glitches never reach btn_db.
        for (int g = 0; g < 3; g++) begin
            add(1, 3, 0,0,0,0, 0,0);
            add(0, 3, 0,0,0,0, 0,0);
        end
        // Long press into EDIT (hold count 20 at edge 25), then two short presses.
        add(1,25, 0,0,0,1, 0,0);
        add(1, 1, 0,0,1,1, 0,0);
        add(1, 4, 0,0,1,1, 0,0);
        add(0, 8, 0,0,1,0, 0,0);
        add(1,10, 0,0,1,1, 0,0);
        add(0, 8, 0,0,1,0, 1,0);
        add(1,10, 0,0,1,1, 1,0);
        add(0, 8, 0,0,1,0, 2,0);
        // Three long presses walk select and leave EDIT.
        add(1,26, 0,1,1,1, 2,0);
        add(1, 4, 0,1,1,1, 2,0);
        add(0, 8, 0,1,1,0, 2,0);
        add(1,26, 0,2,1,1, 2,0);
        add(1, 4, 0,2,1,1, 2,0);
        add(0, 8, 0,2,1,0, 2,0);
        add(1,26, 0,0,0,1, 2,0);
        add(1, 4, 0,0,0,1, 2,0);
        add(0, 8, 0,0,0,0, 2,0);
        // Timeout: editing falls 101 edges after the release edge.
        add(1,30, 0,0,1,1, 2,0);
        add(0, 6, 0,0,1,0, 2,0);
        add(0,100,0,0,1,0, 2,0);
        add(0, 1, 0,0,0,0, 2,0);
        // Short press whose btn_db rises at timeout count 99 restarts the timer.
        add(1,30, 0,0,1,1, 2,0);
        add(0, 6, 0,0,1,0, 2,0);
        add(0,93, 0,0,1,0, 2,0);
        add(1,10, 0,0,1,1, 2,0);
        add(0, 8, 0,0,1,0, 3,0);
        add(0,98, 0,0,1,0, 3,0);
        add(0, 1, 0,0,0,0, 3,0);
        // Stopwatch mode: long press pulses clear, no edit, no mode change on release.
        add(1,10, 0,0,0,1, 3,0);
        add(0, 8, 1,0,0,0, 3,0);
        add(1,10, 1,0,0,1, 3,0);
        add(0, 8, 2,0,0,0, 3,0);
        add(1,26, 2,0,0,1, 3,0);
        add(1, 4, 2,0,0,1, 3,1);
        add(0, 8, 2,0,0,0, 3,1);

        reset = 1'b1;
        btn   = 1'b0;
        step(3);
        chk_all("reset", 0,0,0,0, 0,0);
        chk("reset increment", int'(increment), 0);
        chk("reset clear",     int'(clear),     0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            btn = vecs[i].b;
            step(vecs[i].n);
            chk_all($sformatf("row%0d", i), vecs[i].m, vecs[i].s, vecs[i].ed,
                    vecs[i].db, vecs[i].inc, vecs[i].clr);
        end

        // Reset at hold count 15 in stopwatch mode, button kept held afterwards.
        btn = 1'b1;
        step(20);
        reset = 1'b1;
        #1;
        chk_all("midreset", 0,0,0,0, 3,1);
        chk("midreset increment", int'(increment), 0);
        chk("midreset clear",     int'(clear),     0);
        step(2);
        reset = 1'b0;
        step(5);
        chk("redebounce pre",  int'(btn_db), 0);
        step(1);
        chk("redebounce rise", int'(btn_db), 1);
        step(4);
        btn = 1'b0;
        step(6);
        chk_all("postreset fall", 0,0,0,0, 3,1);
        step(1);
        chk_all("postreset short", 1,0,0,0, 3,1);
        step(20);
        chk_all("postreset idle", 1,0,0,0, 3,1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
